// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues 4-word read bursts to the unified memory from a
// sequential fetch PC, queues the returned words with their PCs and hands them to
// decode over a valid/ready handshake. A redirect flushes everything and restarts
// fetch at the new target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8002_0000,
    parameter int unsigned QDEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    output logic        mem_enable,
    output logic        mem_rd_wr,
    output logic [1:0]  mem_access_size,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        mem_busy,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam int unsigned CntW = PtrW + 1;
    // A burst may only start when all four returning words are guaranteed a slot.
    localparam logic [CntW-1:0] IssueMax = CntW'(QDEPTH - 4);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBurst = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [1:0]      beat_q, beat_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     data_q [QDEPTH];
    logic [31:0]     pc_q   [QDEPTH];

    logic        capture;
    logic [1:0]  cap_idx;
    logic [31:0] cap_pc;
    logic        enq;
    logic        deq;

    // Word i of a burst arrives one cycle after beat i; word 3 lands during DRAIN.
    always_comb begin
        capture = ((state_q == StBurst) && (beat_q != 2'd0)) || (state_q == StDrain);
        cap_idx = (state_q == StDrain) ? 2'd3 : (beat_q - 2'd1);
        cap_pc  = fetch_pc_q + {28'd0, cap_idx, 2'b00};
        enq     = capture && !redirect_valid;
        deq     = inst_valid && inst_ready;
    end

    // Next-state: fetch FSM, queue pointers and occupancy, redirect flush.
    always_comb begin
        state_d    = state_q;
        beat_d     = 2'd0;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (deq) rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({enq, deq})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            StIdle: begin
                if (!mem_busy && (count_q <= IssueMax)) state_d = StBurst;
            end
            StBurst: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) state_d = StDrain;
            end
            StDrain: begin
                fetch_pc_d = fetch_pc_q + 32'd16;
                // Our own burst ends at this edge, so the next one can issue
                // back-to-back when the queue (including word 3) leaves room.
                state_d = (count_d <= IssueMax) ? StBurst : StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (redirect_valid) begin
            state_d    = StIdle;
            beat_d     = 2'd0;
            fetch_pc_d = redirect_pc & ~32'h3;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            beat_q     <= 2'd0;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; cleared on reset so the head reads as zero until filled.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (enq) begin
            data_q[wr_ptr_q] <= mem_data_out;
            pc_q[wr_ptr_q]   <= cap_pc;
        end
    end

    // Memory port and decode-facing outputs.
    always_comb begin
        mem_enable      = (state_q == StBurst);
        mem_addr        = fetch_pc_q;
        mem_rd_wr       = 1'b1;
        mem_access_size = 2'd1;
        mem_data_in     = '0;
        inst_valid      = (count_q != '0);
        inst_data       = data_q[rd_ptr_q];
        inst_pc         = pc_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural burst memory, expected-stream scoreboard and
// directed checks for reset, backpressure, throughput, redirect and reset-with-redirect.
module tb_fetch_unit;

    localparam logic [31:0] RstPc = 32'h8002_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_enable;
    logic        mem_rd_wr;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int checks = 0;
    int errors = 0;
    int deliv_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] run_addr_q[$];
    int          run_len_q[$];
    int          run_moved_q[$];

    fetch_unit #(.RESET_PC(RstPc), .QDEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_rd_wr(mem_rd_wr),
        .mem_access_size(mem_access_size), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_busy(mem_busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    // Memory image: a recognisable preload at the reset PC, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - RstPc;
        if (off < 32'd16) return 32'h11 * ((off >> 2) + 32'd1);
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    // Burst memory: latches address when idle and enabled, returns word i during
    // cycle k+1+i, aborts if enable drops mid-burst.
    logic        m_busy_q = 1'b0;
    logic [1:0]  m_idx_q  = 2'd0;
    logic [31:0] m_base_q = 32'd0;
    always @(posedge clk) begin
        if (m_busy_q) begin
            if (m_idx_q == 2'd3 || !mem_enable) m_busy_q <= 1'b0;
            else m_idx_q <= m_idx_q + 2'd1;
        end else if (mem_enable) begin
            m_busy_q <= 1'b1;
            m_idx_q  <= 2'd0;
            m_base_q <= mem_addr;
        end
    end
    assign mem_busy     = m_busy_q;
    assign mem_data_out = m_busy_q ? mem_word(m_base_q + {28'd0, m_idx_q, 2'b00}) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 1024; i++) exp_q.push_back(pc + 32'(i * 4));
    endtask

    task automatic clear_runs();
        run_addr_q.delete();
        run_len_q.delete();
        run_moved_q.delete();
    endtask

    task automatic apply_reset(input logic rdy);
        reset = 1'b1;
        redirect_valid = 1'b0;
        inst_ready = rdy;
        tick();
        tick();
        restart_stream(RstPc);
        clear_runs();
        reset = 1'b0;
    endtask

    // Bounded wait for the next rising edge of mem_enable (returns in beat 0).
    task automatic wait_burst_start();
        int n = 0;
        while (mem_enable && n < 50) begin tick(); n++; end
        while (!mem_enable && n < 50) begin tick(); n++; end
        if (n >= 50) check("burst_start_timeout", 32'(n), 32'd0);
    endtask

    // Monitor: burst log plus scoreboard pop on every handshake.
    initial begin
        logic        prev_en = 1'b0;
        logic [31:0] cur_addr = '0;
        int          cur_len = 0;
        int          moved = 0;
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            if (mem_enable) begin
                if (!prev_en) begin cur_addr = mem_addr; cur_len = 0; moved = 0; end
                cur_len++;
                if (mem_addr != cur_addr) moved = 1;
            end else if (prev_en) begin
                run_addr_q.push_back(cur_addr);
                run_len_q.push_back(cur_len);
                run_moved_q.push_back(moved);
            end
            prev_en = mem_enable;
            if (!reset && !redirect_valid && inst_valid && inst_ready) begin
                deliv_cnt++;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd0, 32'd1);
                end else begin
                    exp_pc = exp_q.pop_front();
                    check("sb_pc", inst_pc, exp_pc);
                    check("sb_data", inst_data, mem_word(exp_pc));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        logic [31:0] rpc;

        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_mem_enable", 32'(mem_enable), 32'd0);
        check("rst_mem_addr", mem_addr, RstPc);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_rd_wr", 32'(mem_rd_wr), 32'd1);
        check("rst_access_size", 32'(mem_access_size), 32'd1);
        check("rst_data_in", mem_data_in, 32'd0);

        // Basic fetch with continuous ready.
        apply_reset(1'b1);
        repeat (15) tick();
        check("basic_deliv_ge4", 32'(deliv_cnt >= 4), 32'd1);
        if (run_addr_q.size() < 2) begin
            check("basic_burst_count", 32'(run_addr_q.size()), 32'd2);
        end else begin
            check("burst0_addr", run_addr_q[0], RstPc);
            check("burst0_len", 32'(run_len_q[0]), 32'd4);
            check("burst0_addr_stable", 32'(run_moved_q[0]), 32'd0);
            check("burst1_addr", run_addr_q[1], RstPc + 32'h10);
        end

        // Steady-state throughput: 4 words per 5 cycles.
        d0 = deliv_cnt;
        repeat (50) tick();
        check("throughput_50cyc", 32'(deliv_cnt - d0), 32'd40);

        // Backpressure: queue fills with exactly two bursts and holds its head.
        apply_reset(1'b0);
        repeat (30) tick();
        check("bp_burst_count", 32'(run_addr_q.size()), 32'd2);
        check("bp_mem_enable", 32'(mem_enable), 32'd0);
        check("bp_inst_valid", 32'(inst_valid), 32'd1);
        check("bp_head_pc", inst_pc, RstPc);
        check("bp_head_data", inst_data, 32'h11);
        repeat (10) tick();
        check("bp_burst_count_hold", 32'(run_addr_q.size()), 32'd2);
        check("bp_head_pc_hold", inst_pc, RstPc);
        d0 = deliv_cnt;
        inst_ready = 1'b1;
        repeat (8) tick();
        check("bp_drain_8", 32'(deliv_cnt - d0), 32'd8);

        // Redirect at beat 1 of the second burst.
        apply_reset(1'b1);
        wait_burst_start();
        wait_burst_start();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8002_0100;
        restart_stream(32'h8002_0100);
        tick();
        redirect_valid = 1'b0;
        check("redir_mem_enable_low", 32'(mem_enable), 32'd0);
        check("redir_inst_valid_low", 32'(inst_valid), 32'd0);
        n = 0;
        while (!inst_valid && n < 30) begin tick(); n++; end
        check("redir_first_pc", inst_pc, 32'h8002_0100);
        check("redir_first_data", inst_data, mem_word(32'h8002_0100));

        // Unaligned redirect target is word-aligned.
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8002_0103;
        restart_stream(32'h8002_0100);
        tick();
        redirect_valid = 1'b0;
        tick();
        clear_runs();
        repeat (12) tick();
        if (run_addr_q.size() == 0) check("align_burst_seen", 32'd0, 32'd1);
        else check("align_burst_addr", run_addr_q[0], 32'h8002_0100);

        // Reset mid-burst with redirect also asserted.
        wait_burst_start();
        tick();
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h1234_5670;
        tick();
        check("rr_mem_enable", 32'(mem_enable), 32'd0);
        check("rr_mem_addr", mem_addr, RstPc);
        check("rr_inst_valid", 32'(inst_valid), 32'd0);
        check("rr_inst_data", inst_data, 32'd0);
        check("rr_inst_pc", inst_pc, 32'd0);
        tick();
        redirect_valid = 1'b0;
        restart_stream(RstPc);
        clear_runs();
        reset = 1'b0;
        repeat (10) tick();
        if (run_addr_q.size() == 0) check("rr_burst_seen", 32'd0, 32'd1);
        else check("rr_burst_addr", run_addr_q[0], RstPc);

        // Randomized traffic: random ready, random redirects including wrap targets.
        apply_reset(1'b1);
        d0 = deliv_cnt;
        for (int c = 0; c < 1500; c++) begin
            tick();
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                rpc = $urandom;
                if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | (rpc & 32'h1F);
                redirect_valid = 1'b1;
                redirect_pc = rpc;
                restart_stream(rpc & ~32'h3);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        redirect_valid = 1'b0;
        repeat (5) tick();
        check("rand_deliv_ge300", 32'(deliv_cnt - d0 >= 300), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
